vga_timing: RTL and testbench

Source of the VGA timing bus at the head of the video pipeline. The block generates hcount/vcount, sync and blanking for 1024x768 @ 60 Hz (65 MHz pclk). It feeds the first draw stage, which passes the bus through registered. It also emits a once-per-frame tick and a frame counter, which game logic uses to update positions during vertical blank.

---
 rtl/vga_timing.sv | 119 +++++++++++
 tb/tb_vga_timing.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// vga_timing
// ----------
// Free-running VGA timing generator at the head of the video pipeline.
// Produces the pixel/line counters, active-high sync pulses, blanking flags,
// a once-per-frame tick at the start of vertical blank, and a frame counter.
// Default parameters give 1024x768 @ 60 Hz from a 65 MHz pixel clock.
//
// Ports:
//   pclk        in   1   pixel clock
//   rst         in   1   synchronous, active-high reset
//   hcount_out  out  11  current pixel column, 0..H_TOTAL-1
//   vcount_out  out  11  current line, 0..V_TOTAL-1
//   hsync_out   out  1   horizontal sync, active-high
//   vsync_out   out  1   vertical sync, active-high
//   hblnk_out   out  1   high while hcount_out >= H_ACTIVE
//   vblnk_out   out  1   high while vcount_out >= V_ACTIVE
//   frame_tick  out  1   one-cycle pulse at (0, V_ACTIVE)
//   frame_cnt   out  16  frames completed, wraps modulo 2^16
//
// Parameters must satisfy H_ACTIVE+H_FP+H_SYNC <= H_TOTAL <= 2047 and
// V_ACTIVE+V_FP+V_SYNC <= V_TOTAL <= 2047, with V_ACTIVE >= 1.
module vga_timing #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_TOTAL  = 1344,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_TOTAL  = 806
) (
    input  logic        pclk,
    input  logic        rst,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic        frame_tick,
    output logic [15:0] frame_cnt
);

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_BLANK_LO = 11'(H_ACTIVE);
    localparam logic [10:0] V_BLANK_LO = 11'(V_ACTIVE);
    localparam logic [10:0] HS_LO      = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_HI      = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_LO      = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_HI      = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic        frame_tick_q, frame_tick_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Next counter values, then every flag decoded from those next values so
    // that the registered flags line up with the registered counters.
    // Blanking ranges run to the end of the line/frame, so a lower-bound
    // compare is enough for them.
    always_comb begin
        hcount_d = hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = 11'd0;
            if (vcount_q == V_LAST) begin
                vcount_d = 11'd0;
            end else begin
                vcount_d = vcount_q + 11'd1;
            end
        end

        hblnk_d      = (hcount_d >= H_BLANK_LO);
        vblnk_d      = (vcount_d >= V_BLANK_LO);
        hsync_d      = (hcount_d >= HS_LO) && (hcount_d <= HS_HI);
        vsync_d      = (vcount_d >= VS_LO) && (vcount_d <= VS_HI);
        frame_tick_d = (hcount_d == 11'd0) && (vcount_d == V_BLANK_LO);
        frame_cnt_d  = frame_tick_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    // Output registers; reset parks the raster at (0,0) with all flags low
    // and discards any partial-frame count.
    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_q     <= 11'd0;
            vcount_q     <= 11'd0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            hblnk_q      <= 1'b0;
            vblnk_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= 16'd0;
        end else begin
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            hblnk_q      <= hblnk_d;
            vblnk_q      <= vblnk_d;
            frame_tick_q <= frame_tick_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign hcount_out = hcount_q;
    assign vcount_out = vcount_q;
    assign hsync_out  = hsync_q;
    assign vsync_out  = vsync_q;
    assign hblnk_out  = hblnk_q;
    assign vblnk_out  = vblnk_q;
    assign frame_tick = frame_tick_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing
// -------------
// Drives two vga_timing instances from a shared clock and reset: a reduced
// raster (26x13 total) so several whole frames and the frame counter can be
// exercised, and a default 1344x806 raster whose line-level edges are checked.
// Expected outputs come from the elapsed cycle count since reset using plain
// division/modulo arithmetic over the raster geometry.
module tb_vga_timing;

    localparam int SHA = 16, SHF = 2, SHS = 4, SHT = 26;
    localparam int SVA = 8,  SVF = 1, SVS = 2, SVT = 13;
    localparam int DHA = 1024, DHF = 24, DHS = 136, DHT = 1344;
    localparam int DVA = 768,  DVF = 3,  DVS = 6,   DVT = 806;

    logic pclk = 1'b0;
    logic rst  = 1'b1;

    logic [10:0] hc_s, vc_s, hc_d, vc_d;
    logic        hs_s, vs_s, hb_s, vb_s, tk_s;
    logic        hs_d, vs_d, hb_d, vb_d, tk_d;
    logic [15:0] fc_s, fc_d;

    int t_cyc;
    int base_s;
    int vectors;
    int miscompares;

    always #5 pclk = ~pclk;

    vga_timing #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_TOTAL(SHT),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_TOTAL(SVT)
    ) dut_s (
        .pclk(pclk), .rst(rst),
        .hcount_out(hc_s), .vcount_out(vc_s),
        .hsync_out(hs_s), .vsync_out(vs_s),
        .hblnk_out(hb_s), .vblnk_out(vb_s),
        .frame_tick(tk_s), .frame_cnt(fc_s)
    );

    vga_timing dut_d (
        .pclk(pclk), .rst(rst),
        .hcount_out(hc_d), .vcount_out(vc_d),
        .hsync_out(hs_d), .vsync_out(vs_d),
        .hblnk_out(hb_d), .vblnk_out(vb_d),
        .frame_tick(tk_d), .frame_cnt(fc_d)
    );

    // Number of vertical-blank starts reached within t cycles after reset.
    function automatic int ticks_by(input int t, input int ht, input int vt, input int va);
        if (t >= va * ht) return (t - va * ht) / (ht * vt) + 1;
        return 0;
    endfunction

    // Full expected bus {hcount, vcount, hsync, vsync, hblnk, vblnk, tick, cnt}.
    function automatic logic [42:0] model_bus(input int t,
                                              input int ha, input int hf, input int hs, input int ht,
                                              input int va, input int vf, input int vs, input int vt,
                                              input int base);
        int h;
        int v;
        logic hsync, vsync, hblnk, vblnk, tick;
        h     = t % ht;
        v     = (t / ht) % vt;
        hsync = (h >= ha + hf) && (h <= ha + hf + hs - 1);
        vsync = (v >= va + vf) && (v <= va + vf + vs - 1);
        hblnk = (h >= ha);
        vblnk = (v >= va);
        tick  = (h == 0) && (v == va);
        return {11'(h), 11'(v), hsync, vsync, hblnk, vblnk, tick,
                16'(base + ticks_by(t, ht, vt, va))};
    endfunction

    task automatic check_output(input string tag);
        logic [42:0] exp_s, exp_d, act_s, act_d;
        exp_s = model_bus(t_cyc, SHA, SHF, SHS, SHT, SVA, SVF, SVS, SVT, base_s);
        exp_d = model_bus(t_cyc, DHA, DHF, DHS, DHT, DVA, DVF, DVS, DVT, 0);
        act_s = {hc_s, vc_s, hs_s, vs_s, hb_s, vb_s, tk_s, fc_s};
        act_d = {hc_d, vc_d, hs_d, vs_d, hb_d, vb_d, tk_d, fc_d};
        vectors++;
        assert (act_s === exp_s) else begin
            miscompares++;
            $display("[TB] FAIL %s_small t=%0d observed=%h expected=%h", tag, t_cyc, act_s, exp_s);
            $error("[TB] %s_small observed=%h expected=%h", tag, act_s, exp_s);
        end
        vectors++;
        assert (act_d === exp_d) else begin
            miscompares++;
            $display("[TB] FAIL %s_default t=%0d observed=%h expected=%h", tag, t_cyc, act_d, exp_d);
            $error("[TB] %s_default observed=%h expected=%h", tag, act_d, exp_d);
        end
    endtask

    // One clock: drive rst away from the edge, advance the model, check mid-cycle.
    task automatic apply_stimulus(input logic r, input string tag);
        rst = r;
        @(posedge pclk);
        if (r) begin
            t_cyc  = 0;
            base_s = 0;
        end else begin
            t_cyc++;
        end
        @(negedge pclk);
        check_output(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        t_cyc       = 0;
        base_s      = 0;

        // Reset held for three cycles, then the first released cycle.
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, "reset");
        apply_stimulus(1'b0, "release");
        vectors++;
        assert (hc_s === 11'd1 && vc_s === 11'd0 && fc_s === 16'd0) else begin
            miscompares++;
            $display("[TB] FAIL first_cycle observed=(%0d,%0d,%0d) expected=(1,0,0)", hc_s, vc_s, fc_s);
            $error("[TB] first_cycle mismatch");
        end

        // Several small frames plus two full default lines without reset.
        for (int i = 0; i < 2800; i++) apply_stimulus(1'b0, "freerun");

        // Single-cycle reset at a random position in the small frame.
        for (int i = 0, n = $urandom_range(1, 337); i < n; i++) apply_stimulus(1'b0, "prereset");
        apply_stimulus(1'b1, "midreset");
        for (int i = 0; i < 800; i++) apply_stimulus(1'b0, "postreset");

        // Preload the small instance's frame counter to 0xFFFF.
        force dut_s.frame_cnt_q = 16'hFFFF;
        #1;
        release dut_s.frame_cnt_q;
        base_s = 16'hFFFF - ticks_by(t_cyc, SHT, SVT, SVA);
        for (int i = 0; i < 800; i++) apply_stimulus(1'b0, "cntwrap");

        // Random sessions with sporadic reset pulses.
        for (int s = 0; s < 8; s++) begin
            for (int i = 0, n = $urandom_range(50, 900); i < n; i++) begin
                apply_stimulus(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, "random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
